// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - FSM state encoding (2'd3 is illegal and decoded as IDLE by the top)
//   - default operand width
//   - helper to size the bit counter (clog2(W), never narrower than 1 bit)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int count_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor: computes a - b - bin.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when the bits are equal and a
    // borrow is already pending from the lower bit.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial W-bit subtractor, Diff = A - B (mod 2^W) with borrow-out, one bit
// per clock LSB-first through a single full_subtractor cell.
// Ports:
//   clk    in      rising-edge clock
//   rst    in      synchronous active-high reset
//   start  in      begin request, sampled only in IDLE
//   A, B   in  [W] operands, captured on the accepting edge
//   busy   out     high in RUN and DONE
//   done   out     one-cycle pulse when Diff/Bout are updated
//   Diff   out [W] registered difference, held between operations
//   Bout   out     registered final borrow (1 iff A < B unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Diff,
    output logic         Bout
);

    localparam int             CW   = count_width(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_count;
    logic          r_borrow;
    logic [W-1:0]  r_diff;
    logic          r_bout;
    logic          r_busy;
    logic          r_done;

    logic          w_d;
    logic          w_bnext;
    logic [W-1:0]  w_acc_next;

    full_subtractor u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bnext)
    );

    // New difference bits enter at the MSB so that after W shifts the LSB
    // computed first has reached bit 0.
    generate
        if (W == 1) begin : g_acc_w1
            assign w_acc_next = w_d;
        end else begin : g_acc_wn
            assign w_acc_next = {w_d, r_acc[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_acc    <= w_acc_next;
                    r_borrow <= w_bnext;
                    r_count  <= r_count + 1'b1;
                    // The last bit is resolved this cycle; publish the
                    // completed word directly from the cell outputs.
                    if (r_count == LAST) begin
                        r_state <= ST_DONE;
                        r_diff  <= w_acc_next;
                        r_bout  <= w_bnext;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    // IDLE, and the illegal encoding which recovers as IDLE.
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_a_sh   <= A;
                        r_b_sh   <= B;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_borrow <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Diff = r_diff;
    assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed, table-driven bench for serial_subtractor with W=4.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
    );

    // Diff/Bout may only change in a cycle where done is high, or after reset.
    logic         mon_en = 1'b0;
    logic         rst_at_edge = 1'b1;
    logic [W-1:0] prev_diff = '0;
    logic         prev_bout = 1'b0;
    int           stab_viol = 0;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (mon_en && !rst_at_edge && done !== 1'b1 &&
            (Diff !== prev_diff || Bout !== prev_bout))
            stab_viol++;
        prev_diff = Diff;
        prev_bout = Bout;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Single operation: pulse start, measure latency and busy length, check result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_b, input string nm);
        int cyc;
        int busy_cyc;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a;
        B = ~b;
        cyc = 0;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 3 * W + 4) begin
            tick();
            cyc++;
            if (busy === 1'b1) busy_cyc++;
        end
        check({nm, " latency"}, cyc, W);
        check({nm, " diff"}, 32'(Diff), 32'(exp_d));
        check({nm, " bout"}, 32'(Bout), 32'(exp_b));
        tick();
        check({nm, " busy_len"}, busy_cyc, W + 1);
        check({nm, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int got;
        int last_t;
        int dn;
        logic [4:0] full;

        vecs[0] = '{4'b0101, 4'b0011, 4'b0010, 1'b0};
        vecs[1] = '{4'b0011, 4'b0101, 4'b1110, 1'b1};
        vecs[2] = '{4'b0000, 4'b0001, 4'b1111, 1'b1};
        vecs[3] = '{4'b1111, 4'b1111, 4'b0000, 1'b0};
        vecs[4] = '{4'b1011, 4'b0111, 4'b0100, 1'b0};
        vecs[5] = '{4'b1000, 4'b0001, 4'b0111, 1'b0};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{4'b0001, 4'b1111, 4'b0010, 1'b1};

        // Reset, then idle with junk operands and no start.
        A = 4'hF;
        B = 4'h3;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("reset_idle%0d", i), {26'd0, busy, done, Bout, Diff}, 32'd0);
        end

        // Directed vector table.
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));

        // start held high; operands disturbed during the first RUN.
        // DONE always returns to IDLE, which then samples start, so results
        // arrive every W+2 cycles.
        A = 4'b1011;
        B = 4'b0111;
        start = 1'b1;
        tick();
        A = 4'b0000;
        B = 4'b1111;
        got = 0;
        last_t = 0;
        for (int t = 1; t <= 40 && got < 3; t++) begin
            tick();
            if (t == 3) begin
                A = 4'b1011;
                B = 4'b0111;
            end
            if (done === 1'b1) begin
                check($sformatf("held%0d diff", got), 32'(Diff), 32'(4'b0100));
                check($sformatf("held%0d bout", got), 32'(Bout), 32'd0);
                if (got == 0) check("held first latency", t, W);
                else          check($sformatf("held%0d spacing", got), t - last_t, W + 2);
                last_t = t;
                got++;
                if (got == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held result count", got, 3);
        tick();
        tick();
        check("held drained", {31'd0, busy}, 32'd0);

        // Abort mid-RUN with reset.
        A = 4'b1000;
        B = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("abort outputs", {26'd0, busy, done, Bout, Diff}, 32'd0);
        dn = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done === 1'b1 || Diff !== '0 || Bout !== 1'b0) dn++;
        end
        check("abort no done", dn, 0);
        run_op(4'b1000, 4'b0001, 4'b0111, 1'b0, "after_abort");

        // Exhaustive sweep against an arithmetic reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                full = {1'b0, 4'(a)} - {1'b0, 4'(b)};
                run_op(4'(a), 4'(b), full[3:0], (a < b), $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        check("output stability", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
